// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, state and operator encodings for the BCD calculator
//
// Purpose : common definitions imported by calc_seq_ctrl and bcd_addsub2.
// Contents: key codes for operator keys, FSM state encoding, operator encoding.
// Option  : CALC_SUB_EN (subtract support) is honoured by the modules, not here.

package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_EQ  = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // A key code 0..9 is a decimal digit; everything above is a command or ignored.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_addsub2.sv
// rtl/bcd_addsub2.sv - combinational 2-digit BCD adder with optional magnitude subtractor
//
// Purpose : computes A+B (or |A-B| when CALC_SUB_EN is defined) on packed BCD.
// Ports   : a_i   [7:0]  operand A, {tens, ones} BCD
//           b_i   [7:0]  operand B, {tens, ones} BCD
//           sub_i        select subtract (present only with CALC_SUB_EN)
//           res_o [11:0] result magnitude, {hundreds, tens, ones} BCD
//           neg_o        result is negative (A < B while subtracting)
// Option  : CALC_SUB_EN builds the subtract path; otherwise neg_o is tied low.

module bcd_addsub2
    import calc_pkg::*;
(
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
`ifdef CALC_SUB_EN
    input  logic        sub_i,
`endif
    output logic [11:0] res_o,
    output logic        neg_o
);

    logic [4:0]  sum0;
    logic [4:0]  sum1;
    logic        carry0;
    logic        carry1;
    logic [11:0] add_res;

    // Per-digit decimal adjust: a binary digit sum of ten or more gets +6 and carries.
    always_comb begin
        sum0    = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]};
        carry0  = (sum0 >= 5'd10);
        sum1    = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + {4'b0000, carry0};
        carry1  = (sum1 >= 5'd10);
        add_res = {3'b000, carry1,
                   carry1 ? (sum1[3:0] + 4'd6) : sum1[3:0],
                   carry0 ? (sum0[3:0] + 4'd6) : sum0[3:0]};
    end

`ifdef CALC_SUB_EN
    logic        a_lt_b;
    logic [7:0]  big;
    logic [7:0]  small;
    logic [4:0]  diff0;
    logic [4:0]  diff1;
    logic        borrow0;
    logic [11:0] sub_res;

    // Packed BCD orders the same as binary, so a plain compare picks the larger
    // operand; subtracting small from big keeps the magnitude non-negative and a
    // borrowed ones digit is corrected by adding ten back.
    always_comb begin
        a_lt_b  = (a_i < b_i);
        big     = a_lt_b ? b_i : a_i;
        small   = a_lt_b ? a_i : b_i;
        diff0   = {1'b0, big[3:0]} - {1'b0, small[3:0]};
        borrow0 = diff0[4];
        diff1   = {1'b0, big[7:4]} - {1'b0, small[7:4]} - {4'b0000, borrow0};
        sub_res = {4'h0, diff1[3:0],
                   borrow0 ? (diff0[3:0] + 4'd10) : diff0[3:0]};
    end

    assign res_o = sub_i ? sub_res : add_res;
    assign neg_o = sub_i & a_lt_b;
`else
    assign res_o = add_res;
    assign neg_o = 1'b0;
`endif

endmodule

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - keypad sequencer, operand/result registers and display digits
//
// Purpose : collects digit keys into operands A and B, runs the operation on EQ,
//           and drives four registered BCD display digits with leading-zero blanking.
// Ports   : clk           system clock, rising edge
//           rst           synchronous reset, active-high, wins over key_valid
//           key_valid     one-cycle key event strobe
//           key_code [3:0] 0-9 digit, A=ADD, B=SUB, C=EQ, D=CLR, E/F ignored
//           disp0..disp3 [3:0] ones, tens, hundreds, sign display codes
//           state_o [1:0] current state: 0=S_A, 1=S_B, 2=S_RES
//           result_valid  high while in S_RES
// Option  : CALC_SUB_EN enables key B as subtract and the minus-sign display.

module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter logic [3:0] BLANK_CODE = 4'hF,
    parameter logic [3:0] MINUS_CODE = 4'hA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] disp0,
    output logic [3:0] disp1,
    output logic [3:0] disp2,
    output logic [3:0] disp3,
    output logic [1:0] state_o,
    output logic       result_valid
);

    state_e      state_q, state_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [11:0] res_q, res_d;
    logic        neg_q, neg_d;
    logic [3:0]  disp0_q, disp0_d;
    logic [3:0]  disp1_q, disp1_d;
    logic [3:0]  disp2_q, disp2_d;
    logic [3:0]  disp3_q, disp3_d;
    logic        rv_q, rv_d;

    logic [11:0] alu_res;
    logic        alu_neg;
    logic        is_op_key;

`ifdef CALC_SUB_EN
    op_e op_q, op_d;
    assign is_op_key = (key_code == KEY_ADD) || (key_code == KEY_SUB);
`else
    assign is_op_key = (key_code == KEY_ADD);
`endif

    bcd_addsub2 u_alu (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
`ifdef CALC_SUB_EN
        .sub_i (op_q == OP_SUB),
`endif
        .res_o (alu_res),
        .neg_o (alu_neg)
    );

    // Next-state, operand and result update from one key event.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        neg_d   = neg_q;
`ifdef CALC_SUB_EN
        op_d    = op_q;
`endif
        if (key_valid) begin
            if (is_digit(key_code)) begin
                case (state_q)
                    S_A: op_a_d = {op_a_q[3:0], key_code};
                    S_B: op_b_d = {op_b_q[3:0], key_code};
                    default: begin
                        // A digit after a result starts a fresh calculation.
                        op_a_d  = {4'h0, key_code};
                        op_b_d  = 8'h00;
                        neg_d   = 1'b0;
                        state_d = S_A;
                    end
                endcase
            end else if (is_op_key) begin
                if (state_q == S_A) begin
                    op_b_d  = 8'h00;
                    state_d = S_B;
`ifdef CALC_SUB_EN
                    op_d    = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
`endif
                end else if (state_q == S_RES && res_q[11:8] == 4'h0 && !neg_q) begin
                    // Chaining: a two-digit non-negative result becomes operand A.
                    op_a_d  = res_q[7:0];
                    op_b_d  = 8'h00;
                    neg_d   = 1'b0;
                    state_d = S_B;
`ifdef CALC_SUB_EN
                    op_d    = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
`endif
                end
            end else if (key_code == KEY_EQ) begin
                if (state_q == S_B) begin
                    res_d   = alu_res;
                    neg_d   = alu_neg;
                    state_d = S_RES;
                end
            end else if (key_code == KEY_CLR) begin
                state_d = S_A;
                op_a_d  = 8'h00;
                op_b_d  = 8'h00;
                res_d   = 12'h000;
                neg_d   = 1'b0;
`ifdef CALC_SUB_EN
                op_d    = OP_ADD;
`endif
            end
        end
        if (state_q != S_A && state_q != S_B && state_q != S_RES) begin
            state_d = S_A;
        end
    end

    // Display digits are computed from next-state values so they land on the
    // same edge as the key event they reflect.
    always_comb begin
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
        hun = 4'h0;
        ten = 4'h0;
        one = 4'h0;
        case (state_d)
            S_A: begin
                ten = op_a_d[7:4];
                one = op_a_d[3:0];
            end
            S_B: begin
                ten = op_b_d[7:4];
                one = op_b_d[3:0];
            end
            default: begin
                hun = res_d[11:8];
                ten = res_d[7:4];
                one = res_d[3:0];
            end
        endcase
        disp0_d = one;
        disp1_d = (hun != 4'h0 || ten != 4'h0) ? ten : BLANK_CODE;
        disp2_d = (hun != 4'h0) ? hun : BLANK_CODE;
        disp3_d = (state_d == S_RES && neg_d) ? MINUS_CODE : BLANK_CODE;
        rv_d    = (state_d == S_RES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            op_a_q  <= 8'h00;
            op_b_q  <= 8'h00;
            res_q   <= 12'h000;
            neg_q   <= 1'b0;
            disp0_q <= 4'h0;
            disp1_q <= BLANK_CODE;
            disp2_q <= BLANK_CODE;
            disp3_q <= BLANK_CODE;
            rv_q    <= 1'b0;
`ifdef CALC_SUB_EN
            op_q    <= OP_ADD;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            disp0_q <= disp0_d;
            disp1_q <= disp1_d;
            disp2_q <= disp2_d;
            disp3_q <= disp3_d;
            rv_q    <= rv_d;
`ifdef CALC_SUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign disp0        = disp0_q;
    assign disp1        = disp1_q;
    assign disp2        = disp2_q;
    assign disp3        = disp3_q;
    assign state_o      = state_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - self-checking bench for calc_seq_ctrl against a decimal model

module tb_calc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] disp0, disp1, disp2, disp3;
    logic [1:0] state_o;
    logic       result_valid;

    int vectors = 0;
    int miscompares = 0;

    // Decimal model: plain integers, state as 0/1/2.
    int m_state = 0;
    int m_a = 0;
    int m_b = 0;
    int m_res = 0;
    bit m_neg = 0;
    bit m_sub = 0;

`ifdef CALC_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    calc_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .disp0        (disp0),
        .disp1        (disp1),
        .disp2        (disp2),
        .disp3        (disp3),
        .state_o      (state_o),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_neg = 0; m_sub = 0;
    endtask

    task automatic model_apply(input bit r, input bit kv, input logic [3:0] kc);
        int k;
        k = int'(kc);
        if (r) begin
            model_reset();
        end else if (kv) begin
            if (k <= 9) begin
                if (m_state == 0)      m_a = (m_a % 10) * 10 + k;
                else if (m_state == 1) m_b = (m_b % 10) * 10 + k;
                else begin
                    m_a = k; m_b = 0; m_neg = 0; m_state = 0;
                end
            end else if (k == 10 || (k == 11 && SUB_EN)) begin
                if (m_state == 0) begin
                    m_sub = (k == 11); m_b = 0; m_state = 1;
                end else if (m_state == 2 && m_res <= 99 && !m_neg) begin
                    m_a = m_res; m_b = 0; m_sub = (k == 11); m_state = 1;
                end
            end else if (k == 12) begin
                if (m_state == 1) begin
                    if (m_sub) begin
                        m_neg = (m_a < m_b);
                        m_res = m_neg ? (m_b - m_a) : (m_a - m_b);
                    end else begin
                        m_neg = 0;
                        m_res = m_a + m_b;
                    end
                    m_state = 2;
                end
            end else if (k == 13) begin
                model_reset();
            end
        end
    endtask

    function automatic logic [15:0] model_disp();
        int v;
        logic [3:0] h, t, o, s;
        v = (m_state == 0) ? m_a : (m_state == 1) ? m_b : m_res;
        o = 4'((v % 10));
        t = (v >= 10) ? 4'(((v / 10) % 10)) : 4'hF;
        h = (v >= 100) ? 4'((v / 100)) : 4'hF;
        s = (m_state == 2 && m_neg) ? 4'hA : 4'hF;
        return {s, h, t, o};
    endfunction

    task automatic check_model();
        logic [15:0] got, exp;
        got = {disp3, disp2, disp1, disp0};
        exp = model_disp();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL disp: got %h required %h (t=%0t)", got, exp, $time);
        end
        vectors++;
        if (state_o !== 2'(m_state)) begin
            miscompares++;
            $display("FAIL state_o: got %0d required %0d (t=%0t)", state_o, m_state, $time);
        end
        vectors++;
        if (result_valid !== (m_state == 2)) begin
            miscompares++;
            $display("FAIL result_valid: got %0b required %0b (t=%0t)", result_valid, m_state == 2, $time);
        end
    endtask

    task automatic expect_lit(input string name, input logic [15:0] disp_exp, input logic [1:0] st_exp);
        vectors++;
        if ({disp3, disp2, disp1, disp0} !== disp_exp || state_o !== st_exp) begin
            miscompares++;
            $display("FAIL %s: got disp %h state %0d required disp %h state %0d",
                     name, {disp3, disp2, disp1, disp0}, state_o, disp_exp, st_exp);
        end
    endtask

    task automatic step(input bit r, input bit kv, input logic [3:0] kc);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = kc;
        @(posedge clk);
        model_apply(r, kv, kc);
        #1;
        rst = 1'b0; key_valid = 1'b0;
        check_model();
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b0, 1'b1, kc);
    endtask

    initial begin
        // 1. reset
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        expect_lit("reset", 16'hFFF0, 2'd0);

        // 2. 47 + 58 = 105
        key(4'h4); key(4'h7); key(4'hA); key(4'h5); key(4'h8); key(4'hC);
        expect_lit("add_105", 16'hF105, 2'd2);

        // 3. roll of op_a, then CLR
        key(4'h1); key(4'h2); key(4'h3);
        expect_lit("roll", 16'hFF23, 2'd0);
        key(4'hD);
        expect_lit("clr", 16'hFFF0, 2'd0);

        // 4. chaining and the 100 boundary
        key(4'h2); key(4'h0); key(4'hA); key(4'h3); key(4'h0); key(4'hC);
        expect_lit("add_50", 16'hFF50, 2'd2);
        key(4'hA); key(4'h7); key(4'hC);
        expect_lit("chain_57", 16'hFF57, 2'd2);
        key(4'h9); key(4'h9); key(4'hA); key(4'h1); key(4'hC);
        expect_lit("add_100", 16'hF100, 2'd2);
        key(4'hA);
        expect_lit("chain_ignored", 16'hF100, 2'd2);

        // 5. reset wins over a simultaneous EQ
        key(4'hD);
        key(4'h5); key(4'hA); key(4'h5);
        step(1'b1, 1'b1, 4'hC);
        expect_lit("rst_vs_eq", 16'hFFF0, 2'd0);

        // 6. subtract or ignored B key
        key(4'h1); key(4'h2); key(4'hB);
`ifdef CALC_SUB_EN
        expect_lit("sub_enter_b", 16'hFFF0, 2'd1);
        key(4'h3); key(4'h0); key(4'hC);
        expect_lit("sub_neg18", 16'hAF18, 2'd2);
`else
        expect_lit("sub_ignored", 16'hFF12, 2'd0);
        key(4'h3); key(4'h0); key(4'hC);
        expect_lit("sub_roll_30", 16'hFF30, 2'd0);
`endif

        // E/F keys and idle cycles have no effect
        key(4'hE); key(4'hF);
        step(1'b0, 1'b0, 4'hC);

        // Randomized key stream against the model.
        for (int i = 0; i < 1500; i++) begin
            bit r, kv;
            logic [3:0] kc;
            r  = ($urandom_range(0, 199) == 0);
            kv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 6) kc = 4'($urandom_range(0, 9));
            else                          kc = 4'($urandom_range(10, 15));
            // keep CLR rare so long chains and large results happen
            if (kc == 4'hD && $urandom_range(0, 3) != 0) kc = 4'hC;
            step(r, kv, kc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Keypad-driven sequencer for the two-operand BCD calculator.
- Collects decimal key events into two 2-digit BCD operands A and B.
- Sequences the add (optional subtract) operation on "equals".
- Drives four registered BCD display digits for the downstream 7-segment scanner.
- Sits between the debounced keypad decoder and the display mux, and owns all operand and result registers.

Parameters:
BLANK_CODE, 4'hF, display code for a blanked digit (leading-zero suppression)
MINUS_CODE, 4'hA, display code for the minus sign (used only with CALC_SUB_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
key_valid  input  1  one-cycle key event strobe from the debouncer; every high cycle is one event
key_code  input  4  0-9 digit; A=ADD; B=SUB; C=EQ; D=CLR; E,F ignored
disp0  output  4  ones digit (BCD)
disp1  output  4  tens digit or BLANK_CODE
disp2  output  4  hundreds digit or BLANK_CODE
disp3  output  4  BLANK_CODE, or MINUS_CODE for a negative result
state_o  output  2  current FSM state: 0=S_A, 1=S_B, 2=S_RES
result_valid  output  1  high while in S_RES

Behaviour:
- Clock and reset: single clock domain, clk; reset rst is synchronous, active-high, and wins over any simultaneous key_valid.
- Reset values:
  - state = S_A; op_a = op_b = 00; result = 000; neg = 0.
  - disp3..disp0 = BLANK_CODE, BLANK_CODE, BLANK_CODE, 0; result_valid = 0.
- Timing: all outputs are registered. Display reflects a key event on the cycle after key_valid.
- Digit key in S_A or S_B: shift into the active operand, new tens = old ones, new ones = digit. A third digit drops the old tens (roll).
- Digit key in S_RES: op_a = {0, digit}, op_b = 00, go to S_A.
- ADD/SUB in S_A: latch the operator, clear op_b, go to S_B.
- ADD/SUB in S_B: ignored.
- ADD/SUB in S_RES (chaining):
  - If result <= 99 and non-negative: op_a = result, op_b = 00, latch operator, go to S_B.
  - Otherwise: ignored.
- EQ in S_B: result registered on the same edge, go to S_RES; result_valid rises the next cycle.
- EQ in S_A or S_RES: ignored.
- CLR in any state: next cycle equals reset values.
- Codes E/F, and SUB without CALC_SUB_EN: no effect.
- Arithmetic:
  - 2-digit BCD add with decimal adjust per digit: a digit sum > 9 adds 6 and carries.
  - Range 0..198; hundreds digit is 0 or 1.
  - Binary compare thresholds are exact: ones >= 10 carries, not > 9 + 1.
- Display source by state: S_A shows op_a, S_B shows op_b, S_RES shows the 3-digit result.
- Leading-zero suppression: any digit above the most significant non-zero digit shows BLANK_CODE. disp0 is never blanked.

Optional Feature:
CALC_SUB_EN
- Defined:
  - key B selects subtract.
  - S_RES holds |A-B| in BCD (ten's-complement correction) and sets neg when A < B.
  - disp3 = MINUS_CODE when neg, else BLANK_CODE.
  - Chaining from a negative result is ignored.
- Undefined: key B is ignored, no subtract logic is built, neg is tied 0, and disp3 is always BLANK_CODE.

Decomposition:
- Package calc_pkg holds:
  - key codes KEY_ADD/KEY_SUB/KEY_EQ/KEY_CLR;
  - state encodings S_A/S_B/S_RES;
  - op encoding OP_ADD/OP_SUB.
- Sub-module bcd_addsub2: combinational, 2-digit BCD in, 3-digit BCD magnitude plus neg out, with subtract path under CALC_SUB_EN.
- The controller holds the FSM, operand registers and display/blanking registers.

Test Plan:
1. Assert rst 2 cycles -> disp3..0 = F,F,F,0; state_o=0; result_valid=0.
2. Keys 4,7,ADD,5,8,EQ -> after EQ+1: state_o=2, result_valid=1, disp = F,1,0,5 (47+58=105).
3. Keys 1,2,3 in S_A -> op_a rolls: disp = F,F,2,3. Then CLR -> disp = F,F,F,0 next cycle, state_o=0.
4. Keys 2,0,ADD,3,0,EQ -> F,F,5,0. Then ADD,7,EQ -> F,F,5,7. Then 9,9,ADD,1,EQ -> F,1,0,0, and a following ADD is ignored (state_o stays 2).
5. Keys 5,ADD,5 with rst and EQ asserted in the same cycle -> reset values, no result.
6. With CALC_SUB_EN: 1,2,SUB,3,0,EQ -> disp = A,F,1,8. Without the macro: the same sequence leaves state_o=0 after SUB, and op_a rolls to 30: disp = F,F,3,0.
